// File: rtl/cpu_pkg.sv
// Shared loader types and constants.
// Used by the program loader and its bus interface.
package cpu_pkg;

    localparam int INSTR_W = 16;

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_CSUM,
        S_RESP
    } loader_state_t;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Loader bus: uart rx/tx side and instruction RAM side.
// master = loader, slave = environment (uart + imem + cpu).
interface uart_prog_loader_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic               rx_valid;
    logic [7:0]         rx_data;
    logic               tx_busy;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               cpu_hold;
    logic               load_done;
    logic               load_err;

    modport master (
        input  rx_valid, rx_data, tx_busy,
        output tx_start, tx_data,
        output imem_we, imem_addr, imem_wdata,
        output cpu_hold, load_done, load_err
    );

    modport slave (
        output rx_valid, rx_data, tx_busy,
        input  tx_start, tx_data,
        input  imem_we, imem_addr, imem_wdata,
        input  cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/uart_prog_loader.sv
// Program loader: SYNC, COUNT, N x (HI,LO), CSUM frames
// into instruction RAM, answering with one ACK/NAK byte.
module uart_prog_loader
    import cpu_pkg::*;
#(
    parameter int         ADDR_W         = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    uart_prog_loader_if.master bus
);
    localparam int IDX_W = ADDR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    loader_state_t      state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d, n_q, n_d, idx_inc;
    logic [7:0]         csum_q, csum_d, hi_q, hi_d;
    logic [7:0]         resp_q, resp_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic [INSTR_W-1:0] imem_wdata_q, imem_wdata_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               load_done_q, load_done_d;
    logic               load_err_q, load_err_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               counting, tmo_hit, bad_count;

    assign idx_inc   = idx_q + 1'b1;
    assign counting  = (state_q == S_COUNT) || (state_q == S_HI) ||
                       (state_q == S_LO) || (state_q == S_CSUM);
    assign tmo_hit   = counting && !bus.rx_valid &&
                       (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign bad_count = (bus.rx_data == 8'd0) ||
                       (32'(bus.rx_data) > (32'd1 << ADDR_W));

    // Idle-gap counter, cleared by every received byte.
    always_comb begin
        tmo_d = '0;
        if (counting && !bus.rx_valid) tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end

    // Frame parser next-state and registered output values.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        n_d          = n_q;
        csum_d       = csum_q;
        hi_d         = hi_q;
        resp_d       = resp_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_hold_d   = cpu_hold_q;
        load_done_d  = 1'b0;
        load_err_d   = load_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                    state_d    = S_COUNT;
                    cpu_hold_d = 1'b1;
                    load_err_d = 1'b0;
                end
            end
            S_COUNT: begin
                if (bus.rx_valid) begin
                    if (bad_count) begin
                        resp_d  = NAK_BYTE;
                        state_d = S_RESP;
                    end else begin
                        n_d     = IDX_W'(bus.rx_data);
                        csum_d  = bus.rx_data;
                        idx_d   = '0;
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (bus.rx_valid) begin
                    hi_d    = bus.rx_data;
                    csum_d  = csum_q ^ bus.rx_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (bus.rx_valid) begin
                    csum_d       = csum_q ^ bus.rx_data;
                    imem_we_d    = 1'b1;
                    imem_addr_d  = idx_q[ADDR_W-1:0];
                    imem_wdata_d = {hi_q, bus.rx_data};
                    idx_d        = idx_inc;
                    state_d      = (idx_inc == n_q) ? S_CSUM : S_HI;
                end
            end
            S_CSUM: begin
                if (bus.rx_valid) begin
                    resp_d  = (bus.rx_data == csum_q) ? ACK_BYTE
                                                      : NAK_BYTE;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = resp_q;
                    state_d    = S_IDLE;
                    if (resp_q == ACK_BYTE) begin
                        cpu_hold_d  = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (tmo_hit) begin
            resp_d  = NAK_BYTE;
            state_d = S_RESP;
        end
    end

    // Parser state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            n_q          <= '0;
            csum_q       <= '0;
            hi_q         <= '0;
            resp_q       <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            csum_q       <= csum_d;
            hi_q         <= hi_d;
            resp_q       <= resp_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: expected writes
// and response bytes are queued as frames are sent.
module tb_uart_prog_loader;
    import cpu_pkg::*;

    localparam int ADDR_W = 8;
    localparam int TMO    = 300;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    uart_prog_loader #(
        .ADDR_W         (ADDR_W),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int tx_cnt   = 0;
    int done_cnt = 0;

    logic [ADDR_W+15:0] exp_wr[$];
    logic [7:0]         exp_tx[$];
    logic [ADDR_W+15:0] e_wr;
    logic [7:0]         e_tx;

    // Scoreboard: compare each DUT write / response to the queue.
    always @(negedge clk) begin
        if (!rst && bus.imem_we) begin
            checks++;
            if (exp_wr.size() == 0) begin
                failures++;
                $display("FAIL imem_write unexpected: got %h:%h want none",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                e_wr = exp_wr.pop_front();
                if ({bus.imem_addr, bus.imem_wdata} !== e_wr) begin
                    failures++;
                    $display("FAIL imem_write: got %h:%h want %h:%h",
                             bus.imem_addr, bus.imem_wdata,
                             e_wr[ADDR_W+15:16], e_wr[15:0]);
                end
            end
        end
        if (!rst && bus.tx_start) begin
            tx_cnt++;
            checks++;
            if (exp_tx.size() == 0) begin
                failures++;
                $display("FAIL tx_start unexpected: got %h want none",
                         bus.tx_data);
            end else begin
                e_tx = exp_tx.pop_front();
                if (bus.tx_data !== e_tx) begin
                    failures++;
                    $display("FAIL tx_data: got %h want %h",
                             bus.tx_data, e_tx);
                end
            end
        end
        if (!rst && bus.load_done) done_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #1;
    endtask

    task automatic wait_resp(input int base, input int max_cyc,
                             input string name, output int waited);
        waited = 0;
        while (tx_cnt == base && waited < max_cyc) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checks++;
        if (tx_cnt == base) begin
            failures++;
            $display("FAIL %s: no tx_start after %0d cycles, want one",
                     name, max_cyc);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [7:0] csum_of(input logic [7:0] n,
                                           input logic [15:0] w0,
                                           input logic [15:0] w1);
        logic [7:0] c;
        c = n ^ w0[15:8] ^ w0[7:0];
        if (n == 8'd2) c = c ^ w1[15:8] ^ w1[7:0];
        return c;
    endfunction

    task automatic send_good(input string name);
        int b, d, w;
        logic [7:0] cs;
        b  = tx_cnt;
        d  = done_cnt;
        cs = csum_of(8'd2, 16'h1234, 16'hABCD);
        exp_wr.push_back({8'h00, 16'h1234});
        exp_wr.push_back({8'h01, 16'hABCD});
        exp_tx.push_back(ACK_BYTE);
        send_byte(8'hA5);
        chk({name, "_hold_on"}, 32'(bus.cpu_hold), 32'd1);
        chk({name, "_err_clr"}, 32'(bus.load_err), 32'd0);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(cs);
        wait_resp(b, 20, name, w);
        repeat (2) @(negedge clk);
        #1;
        chk({name, "_done"}, 32'(done_cnt), 32'(d + 1));
        chk({name, "_hold_off"}, 32'(bus.cpu_hold), 32'd0);
        chk({name, "_err"}, 32'(bus.load_err), 32'd0);
        chk({name, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_busy  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {bus.tx_start, bus.tx_data, bus.imem_we, bus.imem_addr,
             bus.imem_wdata[12:0], bus.cpu_hold, bus.load_done,
             bus.load_err}, 32'd0);
        chk("reset_wdata_hi", 32'(bus.imem_wdata[15:13]), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_load();
        send_good("good");
    endtask

    task automatic test_bad_csum();
        int b, d, w;
        b = tx_cnt;
        d = done_cnt;
        exp_wr.push_back({8'h00, 16'h1234});
        exp_tx.push_back(NAK_BYTE);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h00);
        wait_resp(b, 20, "bad_csum", w);
        repeat (2) @(negedge clk);
        #1;
        chk("bad_csum_err", 32'(bus.load_err), 32'd1);
        chk("bad_csum_hold", 32'(bus.cpu_hold), 32'd1);
        chk("bad_csum_no_done", 32'(done_cnt), 32'(d));
        chk("bad_csum_wr_left", 32'(exp_wr.size()), 32'd0);
        send_good("recover");
    endtask

    task automatic test_zero_count();
        int b, w;
        b = tx_cnt;
        exp_tx.push_back(NAK_BYTE);
        send_byte(8'hA5);
        send_byte(8'h00);
        wait_resp(b, 20, "zero_count", w);
        repeat (2) @(negedge clk);
        #1;
        chk("zero_count_err", 32'(bus.load_err), 32'd1);
        chk("zero_count_hold", 32'(bus.cpu_hold), 32'd1);
    endtask

    task automatic test_timeout();
        int b, w;
        b = tx_cnt;
        send_good("pre_tmo");
        b = tx_cnt;
        exp_tx.push_back(NAK_BYTE);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        wait_resp(b, TMO + 100, "timeout", w);
        checks++;
        if (w < TMO) begin
            failures++;
            $display("FAIL timeout_early: got %0d cycles want >= %0d",
                     w, TMO);
        end
        repeat (2) @(negedge clk);
        #1;
        chk("timeout_err", 32'(bus.load_err), 32'd1);
        chk("timeout_hold", 32'(bus.cpu_hold), 32'd1);
        chk("timeout_idle", 32'(dut.state_q), 32'(S_IDLE));
    endtask

    task automatic test_noise_busy();
        int b, d, w;
        logic [7:0] cs;
        b = tx_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        repeat (5) @(negedge clk);
        #1;
        chk("noise_no_tx", 32'(tx_cnt), 32'(b));
        chk("noise_err_kept", 32'(bus.load_err), 32'd1);
        d  = done_cnt;
        cs = csum_of(8'd2, 16'h1234, 16'hABCD);
        exp_wr.push_back({8'h00, 16'h1234});
        exp_wr.push_back({8'h01, 16'hABCD});
        exp_tx.push_back(ACK_BYTE);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        bus.tx_busy = 1'b1;
        send_byte(cs);
        send_byte(8'hA5);
        repeat (48) @(negedge clk);
        #1;
        chk("busy_no_tx", 32'(tx_cnt), 32'(b));
        bus.tx_busy = 1'b0;
        wait_resp(b, 20, "busy_release", w);
        repeat (5) @(negedge clk);
        #1;
        chk("busy_one_pulse", 32'(tx_cnt), 32'(b + 1));
        chk("busy_done", 32'(done_cnt), 32'(d + 1));
        chk("resp_drop_sync", 32'(dut.state_q), 32'(S_IDLE));
        chk("busy_hold_off", 32'(bus.cpu_hold), 32'd0);
    endtask

    task automatic test_reset_mid();
        int b;
        b = tx_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        chk("mid_hold_before", 32'(bus.cpu_hold), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_async_outputs",
            {bus.tx_start, bus.tx_data, bus.imem_we, bus.imem_addr,
             bus.imem_wdata[12:0], bus.cpu_hold, bus.load_done,
             bus.load_err}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("mid_no_tx", 32'(tx_cnt), 32'(b));
        send_good("after_rst");
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_csum();
        test_zero_count();
        test_timeout();
        test_noise_busy();
        test_reset_mid();
        chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
